// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps rising edges of a neuron's spike output against
// an enable-gated time-step counter. The timestamps are buffered in a small
// first-word-fall-through FIFO and streamed out over valid/ready. Events that
// arrive while the FIFO is full are dropped and counted.
module spike_event_fifo #(
  parameter int TS_WIDTH  = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 spike_in,
  input  logic                 ts_clear,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [TS_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0] fill_level,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a word transfers on a rising clk edge where out_valid and
  // out_ready are both high. out_valid depends only on registered state and
  // never on out_ready; out_data is the head entry and is meaningful only
  // while out_valid is high.

  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_spike_d;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow;
  logic [7:0]           r_drop_count;
  logic [TS_WIDTH-1:0]  r_mem [DEPTH];

  logic w_event;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts an
  // event when the head is being read.
  assign w_event = enable & spike_in & ~r_spike_d;
  assign w_pop   = (r_count != '0) & out_ready;
  assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & ~w_push;

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign fill_level = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // Spike delay for edge detect (free-running) and the gated time-step counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spike_d <= 1'b0;
      r_ts      <= '0;
    end else begin
      r_spike_d <= spike_in;
      if (ts_clear) begin
        r_ts <= '0;
      end else if (enable) begin
        r_ts <= r_ts + TS_WIDTH'(1);
      end
    end
  end

  // Storage write: an event captures the counter value before this edge's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_ts;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
    end
  end

  // Drop bookkeeping: sticky flag and saturating count; a clear beats a drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (ts_clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Bench for spike_event_fifo: directed steps with a timestamp scoreboard.
module tb_spike_event_fifo;

  localparam int TS_WIDTH  = 8;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 3;

  logic                 clk;
  logic                 reset_n;
  logic                 enable;
  logic                 spike_in;
  logic                 ts_clear;
  logic                 out_ready;
  logic                 out_valid;
  logic [TS_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0] fill_level;
  logic                 overflow;
  logic [7:0]           drop_count;

  spike_event_fifo #(
    .TS_WIDTH (TS_WIDTH),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .spike_in  (spike_in),
    .ts_clear  (ts_clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill_level(fill_level),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard and reference state
  logic [TS_WIDTH-1:0] exp_q[$];
  logic [TS_WIDTH-1:0] m_ts;
  logic                m_spike_d;
  logic                m_ovf;
  logic [7:0]          m_drop;
  logic [TS_WIDTH-1:0] t_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ts      = '0;
    m_spike_d = 1'b0;
    m_ovf     = 1'b0;
    m_drop    = '0;
  endtask

  // One clock: update the reference for the upcoming edge, pop/compare, then
  // sample the DUT 1 time unit after the edge.
  task automatic tick();
    logic ev;
    logic pop;
    ev  = enable & spike_in & ~m_spike_d;
    pop = out_ready && (exp_q.size() != 0);
    if (pop) begin
      check("pop_data", 32'(out_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (ev) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(m_ts);
      end else if (!ts_clear) begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    m_spike_d = spike_in;
    if (ts_clear) begin
      m_ts   = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
    end else if (enable) begin
      m_ts = m_ts + 8'd1;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("fill_level", 32'(fill_level), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    if (exp_q.size() != 0) check("head_data", 32'(out_data), 32'(exp_q[0]));
  endtask

  // Advance (spike low) until the next edge will see timestamp v.
  task automatic run_to(input logic [TS_WIDTH-1:0] v);
    for (int k = 0; k < 600 && m_ts != v; k++) tick();
    if (m_ts != v) begin
      n_vec++;
      n_err++;
      $error("FAIL run_to: observed ts %0d expected %0d (cycle budget expired)", m_ts, v);
    end
  endtask

  task automatic spike_at(input logic [TS_WIDTH-1:0] v);
    spike_in = 1'b0;
    run_to(v);
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    spike_in  = 1'b0;
    ts_clear  = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;

    // basic: spike rises at ts=5, held 3 cycles
    enable = 1'b1;
    spike_at(5);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'd5);
    spike_in = 1'b1;
    tick();
    tick();
    spike_in = 1'b0;
    tick();
    check("basic_one_entry", 32'(fill_level), 32'd1);
    out_ready = 1'b1;
    tick();
    check("basic_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // enable gating: edge while disabled is lost, ts frozen
    t_before = m_ts;
    enable   = 1'b0;
    spike_in = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    tick();
    check("gate_no_recapture", 32'(fill_level), 32'd0);
    spike_in = 1'b0;
    tick();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    check("gate_frozen_ts", 32'(out_data), 32'(t_before + 8'd2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // full / drop
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    for (int i = 1; i <= 6; i++) spike_at(8'(2 * i));
    check("full_fill", 32'(fill_level), 32'd4);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 32'(out_data), 32'(2 * i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);

    // full + simultaneous pop/push at ts=20
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    for (int i = 0; i < 5; i++) spike_at(8'(10 + 2 * i));
    check("pp_drop_before", 32'(drop_count), 32'd1);
    run_to(20);
    out_ready = 1'b1;
    spike_in  = 1'b1;
    tick();
    spike_in = 1'b0;
    check("pp_fill", 32'(fill_level), 32'd4);
    check("pp_drop", 32'(drop_count), 32'd1);
    check("pp_head", 32'(out_data), 32'd12);
    repeat (4) tick();
    out_ready = 1'b0;
    check("pp_empty", 32'(fill_level), 32'd0);

    // wrap then clear coincident with an event at ts=40
    spike_at(1);
    check("wrap_entry", 32'(out_data), 32'd1);
    run_to(40);
    ts_clear = 1'b1;
    spike_in = 1'b1;
    tick();
    ts_clear = 1'b0;
    spike_in = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_count), 32'd0);
    check("clr_fill", 32'(fill_level), 32'd2);
    check("clr_head", 32'(out_data), 32'd1);
    spike_at(1);
    check("clr_ts_restart", 32'(fill_level), 32'd3);
    spike_at(3);
    spike_at(5);
    check("clr_new_drop", 32'(drop_count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_fill", 32'(fill_level), 32'd3);

    // async reset between clock edges
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_fill", 32'(fill_level), 32'd0);
    check("arst_drop", 32'(drop_count), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    check("arst_ts_zero", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
- Sits directly downstream of the recurrent spiking neuron and consumes its spike_out.
- Timestamps each new spike (rising edge) against a free-running time-step counter gated by the neuron's enable.
- Buffers the timestamps in a small FIFO and streams them out over a valid/ready interface to the readout/IO logic.
- Tracks dropped events when the FIFO is full.

Parameters:
- TS_WIDTH, 8, width of the time-step counter and of each FIFO entry.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_WIDTH, 3, width of fill_level; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- enable  input  1  time-step enable; the same signal that drives the neuron's enable.
- spike_in  input  1  neuron spike_out.
- ts_clear  input  1  synchronous clear of the timestamp counter, overflow flag and drop count.
- out_ready  input  1  consumer ready.
- out_valid  output  1  FIFO not empty.
- out_data  output  TS_WIDTH  timestamp at the FIFO head.
- fill_level  output  CNT_WIDTH  number of entries held, 0..DEPTH.
- overflow  output  1  sticky flag: at least one event was dropped.
- drop_count  output  8  dropped events, saturating at 255.

Behaviour:
- Reset (reset_n low, asynchronous): all of the following are 0 immediately:
  - ts counter, spike_d, read/write pointers, every storage entry;
  - out_valid, out_data, fill_level, overflow, drop_count.
- Reset asserted mid-operation discards all buffered events.
- Edge detect:
  - spike_d <= spike_in every cycle, independent of enable.
  - event = enable & spike_in & ~spike_d, evaluated at the clock edge.
  - A spike held high for several cycles produces exactly one event.
  - A rising edge while enable=0 is lost and is not recaptured when enable rises later.
- Timestamp counter:
  - ts <= ts+1 on each edge with enable=1; wraps from 2^TS_WIDTH-1 to 0 with no flag.
  - An event captures the pre-increment value of ts.
- Push:
  - On an event, if not full after the same-cycle pop, write ts at wr_ptr and advance wr_ptr (modulo DEPTH).
  - Otherwise drop the event: overflow <= 1 and drop_count <= min(drop_count+1, 255).
- Pop:
  - Occurs when out_valid & out_ready at the edge; rd_ptr advances.
  - out_data = entry at rd_ptr (first-word-fall-through); its value when out_valid=0 has no meaning.
- Latency: an event at edge N gives out_valid=1 and the timestamp on out_data after edge N (1 cycle).
- Simultaneous events:
  - Full + pop + event: pop then push; the event is accepted, not dropped; fill_level stays DEPTH.
  - Empty + event: no pop possible that cycle (out_valid=0); fill_level becomes 1.
  - Non-empty, non-full + push + pop: fill_level unchanged.
- fill_level:
  - +1 on push only, -1 on pop only, unchanged on both.
  - Never exceeds DEPTH and never underflows.
- ts_clear (synchronous):
  - ts <= 0, overflow <= 0, drop_count <= 0; FIFO contents and pointers are untouched.
  - ts_clear has priority over the enable increment.
  - An event in the same cycle is captured with the pre-clear ts.
  - A drop in the same cycle is not counted; the clear wins.
- out_valid and out_data depend only on registered state; there is no combinational path from out_ready to out_valid.

Test Plan:
- Reset/basic: reset_n low, then high; enable=1; spike_in rises at the cycle where ts=5 and is held 3 cycles -> exactly one entry 5; out_valid=1 one cycle later; with out_ready=1, popped next edge, out_valid returns to 0.
- Enable gating: enable=0 while spike_in pulses, then enable=1 -> no entry; ts frozen while enable=0; the next edge with enable=1 is captured at the correct frozen-then-advanced ts.
- Full/drop: out_ready=0, 6 spikes at ts 2,4,6,8,10,12 -> fill_level=4, entries 2,4,6,8; overflow=1, drop_count=2; drain yields 2,4,6,8 in order.
- Full + simultaneous pop/push: FIFO full, out_ready=1 and an event at ts=20 in the same cycle -> head popped, 20 accepted, fill_level stays 4, drop_count unchanged.
- Wrap + clear: run ts past 255 and spike at ts=1 after the wrap -> entry 1. Assert ts_clear coincident with an event at ts=40 -> entry 40, ts=0 next cycle, overflow and drop_count cleared, FIFO contents retained.
- Async reset mid-stream: 3 entries buffered, then reset_n pulsed low between clock edges -> out_valid, fill_level, ts and drop_count go to 0 without waiting for a clock edge.
